// File: rtl/fan_mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : fan_mode_fsm
//  Description : Fan front-end controller. Synchronizes and debounces four
//                push-buttons, runs the OFF/S1..S4 speed state machine and
//                an auto-off timer that returns the fan to OFF on expiry.
//
//  Ports
//    i_clk            system clock, all logic on rising edge
//    i_reset_n        synchronous active-low reset
//    i_btn_up         raw async button: speed up
//    i_btn_down       raw async button: speed down
//    i_btn_off        raw async button: force OFF
//    i_btn_timer      raw async button: add / cancel auto-off time
//    o_sel[2:0]       registered speed select (0 = off, 1..4 = PWM channel)
//    o_timer_active   auto-off timer armed
//    o_timer_remain   remaining ticks, 0 when not armed
//
//  Revision    : 1.0  initial release
// ============================================================================
module fan_mode_fsm #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 100_000_000,
    parameter int TIMER_W         = 8,
    parameter int TIMER_STEP      = 30,
    parameter int TIMER_MAX       = 90
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_btn_up,
    input  logic               i_btn_down,
    input  logic               i_btn_off,
    input  logic               i_btn_timer,
    output logic [2:0]         o_sel,
    output logic               o_timer_active,
    output logic [TIMER_W-1:0] o_timer_remain
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int c_TICK_W = $clog2(TICK_CYCLES);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);

    // One extra bit so remain + step cannot wrap before the range check.
    localparam logic [TIMER_W:0]   c_STEP    = (TIMER_W + 1)'(TIMER_STEP);
    localparam logic [TIMER_W:0]   c_MAX     = (TIMER_W + 1)'(TIMER_MAX);
    localparam logic [TIMER_W-1:0] c_REM_ONE = TIMER_W'(1);

    localparam int c_BTN_UP    = 0;
    localparam int c_BTN_DOWN  = 1;
    localparam int c_BTN_OFF   = 2;
    localparam int c_BTN_TIMER = 3;

    // State encoding doubles as the speed select code.
    localparam logic [2:0] c_ST_OFF = 3'd0;
    localparam logic [2:0] c_ST_S1  = 3'd1;
    localparam logic [2:0] c_ST_S2  = 3'd2;
    localparam logic [2:0] c_ST_S3  = 3'd3;
    localparam logic [2:0] c_ST_S4  = 3'd4;

    // ------------------------------------------------------------------------
    // Button front end: 2-FF sync, debounce, rising-edge press pulse
    // ------------------------------------------------------------------------
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;

    assign w_btn_raw = {i_btn_timer, i_btn_off, i_btn_down, i_btn_up};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic              r_level_q;
        logic              r_press;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_q <= 1'b0;
                r_press   <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;

                // The counter only runs while the synced level disagrees with
                // the accepted level; any agreement restarts the interval.
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end

                r_level_q <= r_level;
                r_press   <= r_level & ~r_level_q;
            end
        end

        assign w_press[gi] = r_press;
    end

    // ------------------------------------------------------------------------
    // Next speed from button pulses (off > down > up)
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic                r_active;
    logic [TIMER_W-1:0]  r_remain;
    logic [c_TICK_W-1:0] r_presc;

    logic [2:0]         w_spd_next;
    logic               w_tmr_acc;
    logic               w_tick;
    logic               w_expire;
    logic [TIMER_W:0]   w_sum;

    always_comb begin
        w_spd_next = r_state;
        if (w_press[c_BTN_OFF]) begin
            w_spd_next = c_ST_OFF;
        end else if (w_press[c_BTN_DOWN]) begin
            if (r_state != c_ST_OFF) begin
                w_spd_next = r_state - 3'd1;
            end
        end else if (w_press[c_BTN_UP]) begin
            if (r_state != c_ST_S4) begin
                w_spd_next = r_state + 3'd1;
            end
        end
    end

    // A timer press only counts when the fan is running and stays running.
    assign w_tmr_acc = w_press[c_BTN_TIMER] && (r_state != c_ST_OFF) &&
                       (w_spd_next != c_ST_OFF);
    assign w_tick    = r_active && (r_presc == c_TICK_LAST);
    // An accepted press suppresses the decrement, so it also defers expiry.
    assign w_expire  = w_tick && !w_tmr_acc && (r_remain == c_REM_ONE);
    assign w_sum     = {1'b0, r_remain} + c_STEP;

    // ------------------------------------------------------------------------
    // Speed state and auto-off timer
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= c_ST_OFF;
            r_active <= 1'b0;
            r_remain <= '0;
            r_presc  <= '0;
        end else if (w_expire || (w_spd_next == c_ST_OFF)) begin
            // Every path into OFF disarms the timer.
            r_state  <= c_ST_OFF;
            r_active <= 1'b0;
            r_remain <= '0;
            r_presc  <= '0;
        end else begin
            r_state <= w_spd_next;
            if (w_tmr_acc) begin
                r_presc <= '0;
                if (w_sum > c_MAX) begin
                    r_remain <= '0;
                    r_active <= 1'b0;
                end else begin
                    r_remain <= w_sum[TIMER_W-1:0];
                    r_active <= 1'b1;
                end
            end else if (r_active) begin
                if (w_tick) begin
                    r_presc  <= '0;
                    r_remain <= r_remain - c_REM_ONE;
                end else begin
                    r_presc <= r_presc + c_TICK_W'(1);
                end
            end
        end
    end

    assign o_sel          = r_state;
    assign o_timer_active = r_active;
    assign o_timer_remain = r_remain;

endmodule
`default_nettype wire

// File: tb/tb_fan_mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fan_mode_fsm
//  Description : Self-checking bench for fan_mode_fsm. Stimulus pushes the
//                expected outputs for a given clock edge into a scoreboard;
//                a monitor compares them when that edge has occurred.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fan_mode_fsm;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          b_up, b_down, b_off, b_timer;
    logic [2:0]    sel;
    logic          act;
    logic [TW-1:0] rem;

    fan_mode_fsm #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (10),
        .TIMER_W        (TW),
        .TIMER_STEP     (2),
        .TIMER_MAX      (6)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_btn_up      (b_up),
        .i_btn_down    (b_down),
        .i_btn_off     (b_off),
        .i_btn_timer   (b_timer),
        .o_sel         (sel),
        .o_timer_active(act),
        .o_timer_remain(rem)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int            at;
        int            id;
        logic [2:0]    sel;
        logic          act;
        logic [TW-1:0] rem;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_id    = 0;

    // Expected outputs after posedge number 'at'.
    task automatic expect_at(input int at, input int s, input int a, input int r);
        exp_t e;
        e.at  = at;
        e.id  = n_id;
        e.sel = 3'(s);
        e.act = 1'(a);
        e.rem = TW'(r);
        n_id++;
        sb.push_back(e);
    endtask

    // Called at a negedge. Mask bits: {timer, off, down, up}.
    task automatic press(input logic [3:0] m, input int hi, input int lo);
        {b_timer, b_off, b_down, b_up} = m;
        repeat (hi) @(negedge clk);
        {b_timer, b_off, b_down, b_up} = 4'b0000;
        repeat (lo) @(negedge clk);
    endtask

    // Monitor: compares every due scoreboard entry on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at <= edge_cnt) begin
                    n_tests++;
                    if (sb[i].at != edge_cnt || sel !== sb[i].sel ||
                        act !== sb[i].act || rem !== sb[i].rem) begin
                        n_fail++;
                        $display("FAIL chk%0d edge %0d (due %0d): got sel=%0d act=%0b rem=%0d, want sel=%0d act=%0b rem=%0d",
                                 sb[i].id, edge_cnt, sb[i].at, sel, act, rem,
                                 sb[i].sel, sb[i].act, sb[i].rem);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // Speed table: button mask and expected o_sel after each press.
    int spd_mask [20] = '{1, 1, 1, 1, 1,  2, 2, 2, 2, 2,  1, 1, 1, 4,  1, 1, 3,  1, 1, 5};
    int spd_exp  [20] = '{1, 2, 3, 4, 4,  3, 2, 1, 0, 0,  1, 2, 3, 0,  1, 2, 1,  2, 3, 0};

    int n;

    initial begin
        reset_n = 1'b0;
        {b_timer, b_off, b_down, b_up} = 4'b1111;

        // Reset held 3 edges with all buttons high.
        @(negedge clk);
        n_tests++;
        if (sel !== 3'd0 || act !== 1'b0 || rem !== TW'(0)) begin
            n_fail++;
            $display("FAIL direct reset: got sel=%0d act=%0b rem=%0d, want sel=0 act=0 rem=0",
                     sel, act, rem);
        end
        expect_at(edge_cnt + 1, 0, 0, 0);
        expect_at(edge_cnt + 2, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = edge_cnt;
        // Buttons still held: off dominates after the debounce interval.
        expect_at(n + 7, 0, 0, 0);
        expect_at(n + 8, 0, 0, 0);
        expect_at(n + 12, 0, 0, 0);
        repeat (12) @(negedge clk);
        {b_timer, b_off, b_down, b_up} = 4'b0000;
        repeat (12) @(negedge clk);
        n_tests++;
        if (sel !== 3'd0 || act !== 1'b0 || rem !== TW'(0)) begin
            n_fail++;
            $display("FAIL direct all-held: got sel=%0d act=%0b rem=%0d, want sel=0 act=0 rem=0",
                     sel, act, rem);
        end

        // 3-cycle glitch on up: rejected.
        n = edge_cnt;
        expect_at(n + 8, 0, 0, 0);
        expect_at(n + 12, 0, 0, 0);
        press(4'b0001, 3, 12);

        // Held up: exact latency, one step only.
        n = edge_cnt;
        expect_at(n + 7, 0, 0, 0);
        expect_at(n + 8, 1, 0, 0);
        expect_at(n + 20, 1, 0, 0);
        press(4'b0001, 20, 10);

        // Off from S1.
        n = edge_cnt;
        expect_at(n + 8, 0, 0, 0);
        press(4'b0100, 6, 10);

        // Sweep, saturation, off, and simultaneous-press priority.
        for (int i = 0; i < 20; i++) begin
            n = edge_cnt;
            expect_at(n + 8, spd_exp[i], 0, 0);
            press(4'(spd_mask[i]), 6, 10);
        end

        // Single timer press at S2, then expiry after 20 cycles.
        n = edge_cnt; expect_at(n + 8, 1, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt; expect_at(n + 8, 2, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt;
        expect_at(n + 8, 2, 1, 2);
        expect_at(n + 17, 2, 1, 2);
        expect_at(n + 18, 2, 1, 1);
        expect_at(n + 27, 2, 1, 1);
        expect_at(n + 28, 0, 0, 0);
        press(4'b1000, 6, 10);
        repeat (16) @(negedge clk);

        // Four quick timer presses: 2, 4, 6, then cancel.
        n = edge_cnt; expect_at(n + 8, 1, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt; expect_at(n + 8, 2, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt;
        expect_at(n + 8, 2, 1, 2);
        expect_at(n + 15, 2, 1, 2);
        expect_at(n + 16, 2, 1, 4);
        expect_at(n + 24, 2, 1, 6);
        expect_at(n + 32, 2, 0, 0);
        expect_at(n + 40, 2, 0, 0);
        for (int i = 0; i < 4; i++) press(4'b1000, 4, 4);
        repeat (12) @(negedge clk);

        // Timer press in OFF is ignored.
        n = edge_cnt; expect_at(n + 8, 0, 0, 0); press(4'b0100, 6, 10);
        n = edge_cnt;
        expect_at(n + 8, 0, 0, 0);
        expect_at(n + 12, 0, 0, 0);
        press(4'b1000, 6, 10);
        n_tests++;
        if (sel !== 3'd0 || act !== 1'b0 || rem !== TW'(0)) begin
            n_fail++;
            $display("FAIL direct timer-in-off: got sel=%0d act=%0b rem=%0d, want sel=0 act=0 rem=0",
                     sel, act, rem);
        end

        // Up pulse lands on the expiry edge: expiry wins.
        n = edge_cnt; expect_at(n + 8, 1, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt;
        expect_at(n + 8, 1, 1, 2);
        expect_at(n + 18, 1, 1, 1);
        expect_at(n + 27, 1, 1, 1);
        expect_at(n + 28, 0, 0, 0);
        expect_at(n + 36, 0, 0, 0);
        press(4'b1000, 6, 10);
        repeat (4) @(negedge clk);
        press(4'b0001, 6, 10);

        // Reset while armed clears everything on the next edge.
        n = edge_cnt; expect_at(n + 8, 1, 0, 0); press(4'b0001, 6, 10);
        n = edge_cnt;
        expect_at(n + 8, 1, 1, 2);
        expect_at(n + 12, 1, 1, 2);
        expect_at(n + 13, 0, 0, 0);
        expect_at(n + 20, 0, 0, 0);
        press(4'b1000, 6, 4);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (sel !== 3'd0 || act !== 1'b0 || rem !== TW'(0)) begin
            n_fail++;
            $display("FAIL direct post-reset: got sel=%0d act=%0b rem=%0d, want sel=0 act=0 rem=0",
                     sel, act, rem);
        end

        // Drain with a bound; anything left over was never checked.
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL chk%0d timeout: got no check by edge %0d, want check at edge %0d",
                     sb[i].id, edge_cnt, sb[i].at);
        end

        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL check count: got %0d checks, want at least 12", n_tests);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
